sec_scrub_ctrl: RTL

//  Walks a 40-bit-word memory (32 data + 8 check bits) and passes each word through
//  the external single-error-correcting (SEC) corrector. Writes back every word whose

---
 rtl/sec_scrub_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/sec_scrub_ctrl.sv
// Memory scrubber: reads each word, runs it through the external SEC corrector,
// writes back words whose data was corrected and counts them (saturating).
module sec_scrub_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [39:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [39:0]       mem_rdata,
  output logic              sec_en,
  output logic [31:0]       sec_din,
  output logic [7:0]        sec_chk,
  input  logic [31:0]       sec_dout
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_CHECK, S_WR_REQ, S_NEXT, S_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       din_q, din_d;
  logic [7:0]        chk_q, chk_d;
  logic [39:0]       wdata_q, wdata_d;
  logic              req_q, we_q, en_q, busy_q, done_q;
  logic              req_d, we_d, en_d, busy_d, done_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    chk_d   = chk_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d = S_RD_REQ;
        addr_d  = '0;
        cnt_d   = '0;
      end
      S_RD_REQ:  if (mem_gnt) state_d = S_RD_WAIT;
      S_RD_WAIT: if (mem_rvalid) begin
        din_d   = mem_rdata[31:0];
        chk_d   = mem_rdata[39:32];
        state_d = S_CHECK;
      end
      S_CHECK: begin
        // Write-back word is latched here so it is stable for the whole WR_REQ wait
        wdata_d = {chk_q, sec_dout};
        if (sec_dout != din_q) begin
          state_d = S_WR_REQ;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d = S_NEXT;
        end
      end
      S_WR_REQ: if (mem_gnt) state_d = S_NEXT;
      S_NEXT: begin
        if (addr_q == LAST_ADDR || stop) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_RD_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q
  always_comb begin
    req_d  = (state_d == S_RD_REQ) || (state_d == S_WR_REQ);
    we_d   = (state_d == S_WR_REQ);
    en_d   = (state_d == S_CHECK);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      din_q   <= '0;
      chk_q   <= '0;
      wdata_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      chk_q   <= chk_d;
      wdata_q <= wdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err_cnt   = cnt_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign sec_en    = en_q;
  assign sec_din   = din_q;
  assign sec_chk   = chk_q;

endmodule
